// File: rtl/pipelined_look_ahead_borrow_subtractor_8_bit_if.sv
// Operand/result handshake bundle for the 8-bit lookahead-borrow subtractor.
// The master side is the operand producer, which is also the result consumer.
interface pipelined_look_ahead_borrow_subtractor_8_bit_if;
    logic       Valid_In;
    logic       Ready_Out;
    logic [7:0] Data_A_In;
    logic [7:0] Data_B_In;
    logic       Borrow_In;
    logic       Valid_Out;
    logic       Ready_In;

    modport master (
        output Valid_In, Data_A_In, Data_B_In, Borrow_In, Ready_In,
        input  Ready_Out, Valid_Out
    );
    modport slave (
        input  Valid_In, Data_A_In, Data_B_In, Borrow_In, Ready_In,
        output Ready_Out, Valid_Out
    );
endinterface

// File: rtl/pipelined_look_ahead_borrow_subtractor_8_bit.sv
// Two-stage 8-bit subtractor A - B - Borrow_In built from two 4-bit borrow-lookahead groups.
// S1 resolves the low nibble and the borrow into bit 4; S2 resolves the high nibble and the flags.
module pipelined_look_ahead_borrow_subtractor_8_bit (
    input  logic       Clock_In,
    input  logic       Reset_n_In,
    input  logic       Enable_In,
    pipelined_look_ahead_borrow_subtractor_8_bit_if.slave bus,
    output wire  [7:0] Difference_Out,
    output wire        Borrow_Out,
    output wire        Overflow_Out
);

    // Group generate/propagate of a nibble; a borrow leaves the nibble when G, or when P and a borrow entered.
    function automatic logic [1:0] nib_gp(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] g, p;
        g = ~a & b;
        p = ~(a ^ b);
        nib_gp = {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
    endfunction

    function automatic logic [3:0] nib_diff(input logic [3:0] a, input logic [3:0] b, input logic bin);
        logic [3:0] g, p, c;
        g    = ~a & b;
        p    = ~(a ^ b);
        c[0] = bin;
        c[1] = g[0] | (p[0] & bin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
        nib_diff = a ^ b ^ c;
    endfunction

    logic       s1_vld_q, s1_vld_d;
    logic [3:0] s1_dlo_q, s1_dlo_d;
    logic       s1_b4_q, s1_b4_d;
    logic [3:0] s1_ahi_q, s1_ahi_d;
    logic [3:0] s1_bhi_q, s1_bhi_d;
    logic       s1_g_q, s1_g_d;
    logic       s1_p_q, s1_p_d;
    logic       s2_vld_q, s2_vld_d;
    logic [7:0] s2_diff_q, s2_diff_d;
    logic       s2_bout_q, s2_bout_d;
    logic       s2_ovf_q, s2_ovf_d;

    logic       s2_ld, s1_ld, accept;
    logic [1:0] gp_lo, gp_hi;
    logic [3:0] dhi;

    // Enable gates both load strobes, so a disabled block freezes in place.
    assign s2_ld  = Enable_In & (~s2_vld_q | bus.Ready_In);
    assign s1_ld  = Enable_In & (~s1_vld_q | s2_ld);
    assign accept = s1_ld & bus.Valid_In;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_dlo_d  = s1_dlo_q;
        s1_b4_d   = s1_b4_q;
        s1_ahi_d  = s1_ahi_q;
        s1_bhi_d  = s1_bhi_q;
        s1_g_d    = s1_g_q;
        s1_p_d    = s1_p_q;
        s2_vld_d  = s2_vld_q;
        s2_diff_d = s2_diff_q;
        s2_bout_d = s2_bout_q;
        s2_ovf_d  = s2_ovf_q;
        gp_lo     = nib_gp(bus.Data_A_In[3:0], bus.Data_B_In[3:0]);
        gp_hi     = nib_gp(bus.Data_A_In[7:4], bus.Data_B_In[7:4]);
        dhi       = nib_diff(s1_ahi_q, s1_bhi_q, s1_b4_q);

        if (s1_ld) s1_vld_d = bus.Valid_In;
        if (accept) begin
            s1_dlo_d = nib_diff(bus.Data_A_In[3:0], bus.Data_B_In[3:0], bus.Borrow_In);
            s1_b4_d  = gp_lo[1] | (gp_lo[0] & bus.Borrow_In);
            s1_ahi_d = bus.Data_A_In[7:4];
            s1_bhi_d = bus.Data_B_In[7:4];
            s1_g_d   = gp_hi[1];
            s1_p_d   = gp_hi[0];
        end

        if (s2_ld) s2_vld_d = s1_vld_q;
        if (s2_ld && s1_vld_q) begin
            s2_diff_d = {dhi, s1_dlo_q};
            s2_bout_d = s1_g_q | (s1_p_q & s1_b4_q);
            s2_ovf_d  = (s1_ahi_q[3] ^ s1_bhi_q[3]) & (dhi[3] ^ s1_ahi_q[3]);
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            s1_vld_q  <= 1'b0;
            s1_dlo_q  <= 4'h0;
            s1_b4_q   <= 1'b0;
            s1_ahi_q  <= 4'h0;
            s1_bhi_q  <= 4'h0;
            s1_g_q    <= 1'b0;
            s1_p_q    <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_diff_q <= 8'h00;
            s2_bout_q <= 1'b0;
            s2_ovf_q  <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_dlo_q  <= s1_dlo_d;
            s1_b4_q   <= s1_b4_d;
            s1_ahi_q  <= s1_ahi_d;
            s1_bhi_q  <= s1_bhi_d;
            s1_g_q    <= s1_g_d;
            s1_p_q    <= s1_p_d;
            s2_vld_q  <= s2_vld_d;
            s2_diff_q <= s2_diff_d;
            s2_bout_q <= s2_bout_d;
            s2_ovf_q  <= s2_ovf_d;
        end
    end

    assign bus.Ready_Out  = s1_ld;
    assign bus.Valid_Out  = Enable_In & s2_vld_q;
    assign Difference_Out = Enable_In ? s2_diff_q : 8'hzz;
    assign Borrow_Out     = Enable_In ? s2_bout_q : 1'bz;
    assign Overflow_Out   = Enable_In ? s2_ovf_q : 1'bz;

endmodule

// File: tb/tb_pipelined_look_ahead_borrow_subtractor_8_bit.sv
// Directed and random stimulus for the pipelined subtractor; results are checked in order
// against a queue of expected {overflow, borrow, difference} words.
module tb_pipelined_look_ahead_borrow_subtractor_8_bit;

    logic       Clock_In = 1'b0;
    logic       Reset_n_In;
    logic       Enable_In;
    wire  [7:0] Difference_Out;
    wire        Borrow_Out;
    wire        Overflow_Out;

    pipelined_look_ahead_borrow_subtractor_8_bit_if bus ();

    pipelined_look_ahead_borrow_subtractor_8_bit dut (
        .Clock_In       (Clock_In),
        .Reset_n_In     (Reset_n_In),
        .Enable_In      (Enable_In),
        .bus            (bus.slave),
        .Difference_Out (Difference_Out),
        .Borrow_Out     (Borrow_Out),
        .Overflow_Out   (Overflow_Out)
    );

    always #5 Clock_In = ~Clock_In;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [9:0] exp_q[$];
    logic       rnd_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference built from plain integer arithmetic, independent of the lookahead structure.
    function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [8:0] r;
        int         s;
        r = {1'b0, a} - {1'b0, b} - {8'h00, bin};
        s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        ref_sub = {(s < -128 || s > 127), r[8], r[7:0]};
    endfunction

    // Drives one beat starting just after a rising edge and returns just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic [9:0] exp);
        logic acc = 1'b0;
        bus.Valid_In  = 1'b1;
        bus.Data_A_In = a;
        bus.Data_B_In = b;
        bus.Borrow_In = bin;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge Clock_In);
            acc = bus.Ready_Out;
            if (acc) exp_q.push_back(exp);
            @(posedge Clock_In);
            #1;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        bus.Valid_In = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge Clock_In);
        #1;
    endtask

    // Result monitor: in-order scoreboard plus hold-stable check while stalled.
    logic       hold_v = 1'b0;
    logic [9:0] hold_val;
    always @(negedge Clock_In) begin
        logic [9:0] obs;
        obs = {Overflow_Out, Borrow_Out, Difference_Out};
        if (hold_v && bus.Valid_Out) check("stall_hold", {22'h0, obs}, {22'h0, hold_val});
        hold_v   = bus.Valid_Out && !bus.Ready_In;
        hold_val = obs;
        if (bus.Valid_Out && bus.Ready_In) begin
            if (exp_q.size() == 0) check("spurious_beat", 32'd1, 32'd0);
            else check("result", {22'h0, obs}, {22'h0, exp_q.pop_front()});
        end
    end

    initial begin
        Reset_n_In    = 1'b0;
        Enable_In     = 1'b1;
        bus.Valid_In  = 1'b0;
        bus.Ready_In  = 1'b1;
        bus.Data_A_In = 8'h00;
        bus.Data_B_In = 8'h00;
        bus.Borrow_In = 1'b0;
        rnd_done      = 1'b0;
        #2;
        check("rst_valid", {31'h0, bus.Valid_Out}, 32'd0);
        check("rst_diff", {24'h0, Difference_Out}, 32'h00);
        check("rst_borrow", {31'h0, Borrow_Out}, 32'd0);
        check("rst_ovf", {31'h0, Overflow_Out}, 32'd0);
        check("rst_ready", {31'h0, bus.Ready_Out}, 32'd1);
        cycles(2);
        Reset_n_In = 1'b1;
        @(negedge Clock_In);
        check("ready_after_rst", {31'h0, bus.Ready_Out}, 32'd1);
        @(posedge Clock_In); #1;

        // Directed vectors with latency check on the first.
        send(8'h00, 8'h01, 1'b0, {1'b0, 1'b1, 8'hFF});
        @(negedge Clock_In);
        check("lat_s1", {31'h0, bus.Valid_Out}, 32'd0);
        @(negedge Clock_In);
        check("lat_s2", {31'h0, bus.Valid_Out}, 32'd1);
        @(posedge Clock_In); #1;
        send(8'h80, 8'h01, 1'b0, {1'b1, 1'b0, 8'h7F});
        send(8'h10, 8'h0F, 1'b1, {1'b0, 1'b0, 8'h00});
        send(8'hFF, 8'hFF, 1'b1, {1'b0, 1'b1, 8'hFF});
        send(8'h7F, 8'h80, 1'b0, {1'b1, 1'b1, 8'hFF});
        send(8'h05, 8'h03, 1'b1, {1'b0, 1'b0, 8'h01});
        cycles(4);
        check("drain_directed", exp_q.size(), 32'd0);

        // Eight back-to-back beats with a 3-cycle downstream stall in the middle.
        fork
            for (int i = 0; i < 8; i++)
                send(8'(8'h20 + 8'(i * 17)), 8'(8'h31 * i), 1'(i & 1),
                     ref_sub(8'(8'h20 + 8'(i * 17)), 8'(8'h31 * i), 1'(i & 1)));
            begin
                cycles(4);
                bus.Ready_In = 1'b0;
                @(negedge Clock_In);
                check("full_ready_low", {31'h0, bus.Ready_Out}, 32'd0);
                cycles(3);
                bus.Ready_In = 1'b1;
            end
        join
        cycles(4);
        check("drain_stall", exp_q.size(), 32'd0);

        // Enable low for 5 cycles mid-stream.
        fork
            for (int i = 0; i < 10; i++)
                send(8'(i * 29), 8'(8'hC3 - i), 1'(i % 3 == 0), ref_sub(8'(i * 29), 8'(8'hC3 - i), 1'(i % 3 == 0)));
            begin
                cycles(3);
                Enable_In = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge Clock_In);
                    check("dis_valid", {31'h0, bus.Valid_Out}, 32'd0);
                    check("dis_ready", {31'h0, bus.Ready_Out}, 32'd0);
                end
                @(posedge Clock_In); #1;
                Enable_In = 1'b1;
            end
        join
        cycles(4);
        check("drain_enable", exp_q.size(), 32'd0);

        // Asynchronous reset with both stages full.
        bus.Ready_In = 1'b0;
        send(8'h44, 8'h11, 1'b0, ref_sub(8'h44, 8'h11, 1'b0));
        send(8'h55, 8'h22, 1'b0, ref_sub(8'h55, 8'h22, 1'b0));
        @(negedge Clock_In);
        check("pre_rst_valid", {31'h0, bus.Valid_Out}, 32'd1);
        #2;
        Reset_n_In = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", {31'h0, bus.Valid_Out}, 32'd0);
        check("async_rst_diff", {24'h0, Difference_Out}, 32'h00);
        bus.Ready_In = 1'b1;
        cycles(2);
        Reset_n_In = 1'b1;
        cycles(5);
        check("no_stale_beat", exp_q.size(), 32'd0);

        // Random beats with random back-pressure and enable.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [7:0] a, b;
                    logic       c;
                    a = 8'($urandom);
                    b = 8'($urandom);
                    c = 1'($urandom);
                    send(a, b, c, ref_sub(a, b, c));
                    if ($urandom_range(0, 3) == 0) cycles(1);
                end
                rnd_done = 1'b1;
            end
            while (!rnd_done) begin
                @(posedge Clock_In); #1;
                bus.Ready_In = ($urandom_range(0, 3) != 0);
                Enable_In    = ($urandom_range(0, 7) != 0);
            end
        join
        bus.Ready_In = 1'b1;
        Enable_In    = 1'b1;
        cycles(6);
        check("drain_random", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
